// File: rtl/treadmill_pkg.sv
// Shared types and BCD helpers for the setpoint counter and its key front-end.
//   bcd_digit_t   : one BCD digit
//   key_state_t   : per-key FSM state (IDLE, HOLD, REPEAT)
//   bcd_inc/dec   : per-digit carry/borrow increment/decrement on up to 4 digits
//   bcd_to_bin    : weighted-sum conversion (multiplies by constants only)
//   bcd_valid     : all digits in 0..9
//   bin_to_bcd    : elaboration-time constant conversion (uses divide, constants only)
package treadmill_pkg;

   localparam int unsigned MAX_DIGITS = 4;
   localparam int unsigned BCD_MAX_W  = 4 * MAX_DIGITS;

   typedef logic [3:0] bcd_digit_t;
   localparam bcd_digit_t DIGIT_MAX = 4'd9;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      HOLD   = 2'd1,
      REPEAT = 2'd2
   } key_state_t;

   // Increment the low n digits; carry ripples 9 -> 0 into the next digit.
   function automatic logic [BCD_MAX_W-1:0] bcd_inc(input logic [BCD_MAX_W-1:0] v,
                                                    input int unsigned n);
      logic [BCD_MAX_W-1:0] r;
      logic                 carry;
      r     = v;
      carry = 1'b1;
      for (int unsigned i = 0; i < MAX_DIGITS; i++) begin
         if (i < n && carry) begin
            if (r[4*i +: 4] == DIGIT_MAX) begin
               r[4*i +: 4] = 4'd0;
            end else begin
               r[4*i +: 4] = r[4*i +: 4] + 4'd1;
               carry       = 1'b0;
            end
         end
      end
      return r;
   endfunction

   // Decrement the low n digits; borrow ripples 0 -> 9 into the next digit.
   function automatic logic [BCD_MAX_W-1:0] bcd_dec(input logic [BCD_MAX_W-1:0] v,
                                                    input int unsigned n);
      logic [BCD_MAX_W-1:0] r;
      logic                 borrow;
      r      = v;
      borrow = 1'b1;
      for (int unsigned i = 0; i < MAX_DIGITS; i++) begin
         if (i < n && borrow) begin
            if (r[4*i +: 4] == 4'd0) begin
               r[4*i +: 4] = DIGIT_MAX;
            end else begin
               r[4*i +: 4] = r[4*i +: 4] - 4'd1;
               borrow      = 1'b0;
            end
         end
      end
      return r;
   endfunction

   // Weighted sum of the low n digits.
   function automatic logic [BCD_MAX_W-1:0] bcd_to_bin(input logic [BCD_MAX_W-1:0] v,
                                                       input int unsigned n);
      int unsigned acc;
      int unsigned weight;
      acc    = 0;
      weight = 1;
      for (int unsigned i = 0; i < MAX_DIGITS; i++) begin
         if (i < n) begin
            acc    = acc + 32'(v[4*i +: 4]) * weight;
            weight = weight * 10;
         end
      end
      return BCD_MAX_W'(acc);
   endfunction

   // True when every one of the low n digits is a legal BCD digit.
   function automatic logic bcd_valid(input logic [BCD_MAX_W-1:0] v,
                                      input int unsigned n);
      logic ok;
      ok = 1'b1;
      for (int unsigned i = 0; i < MAX_DIGITS; i++) begin
         if (i < n && v[4*i +: 4] > DIGIT_MAX) ok = 1'b0;
      end
      return ok;
   endfunction

   // Constant conversion for parameters only; never used on live signals.
   function automatic logic [BCD_MAX_W-1:0] bin_to_bcd(input int unsigned v);
      logic [BCD_MAX_W-1:0] r;
      int unsigned          t;
      r = '0;
      t = v;
      for (int unsigned i = 0; i < MAX_DIGITS; i++) begin
         r[4*i +: 4] = 4'(t % 10);
         t           = t / 10;
      end
      return r;
   endfunction

endpackage

// File: rtl/key_repeat.sv
// Single push-button front end: 2-flop synchroniser, tap/hold/auto-repeat FSM.
//   CLOCK_50  in  system clock
//   reset     in  asynchronous active-low reset
//   key_n     in  raw button, active-low, asynchronous
//   clear     in  force IDLE and block until this key releases
//   step_req  out combinational step request for the current cycle
//   pressed   out synchronised key level (1 = held)
module key_repeat
   import treadmill_pkg::*;
#(
   parameter int unsigned HOLD_CYCLES   = 25000000,
   parameter int unsigned REPEAT_CYCLES = 5000000
) (
   input  logic CLOCK_50,
   input  logic reset,
   input  logic key_n,
   input  logic clear,
   output logic step_req,
   output logic pressed
);

   localparam int unsigned CNT_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
   localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
   localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);

   logic             sync_1, sync_2;
   key_state_t       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             blocked_q, blocked_d;

   // Synchroniser; resets to released so a held key after reset is a fresh press.
   always_ff @(posedge CLOCK_50 or negedge reset) begin
      if (!reset) begin
         sync_1 <= 1'b1;
         sync_2 <= 1'b1;
      end else begin
         sync_1 <= key_n;
         sync_2 <= sync_1;
      end
   end

   assign pressed = ~sync_2;

   // State register.
   always_ff @(posedge CLOCK_50 or negedge reset) begin
      if (!reset) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         blocked_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         blocked_q <= blocked_d;
      end
   end

   // Next state and step request; a blocked key waits for release before re-arming.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      blocked_d = blocked_q;
      step_req  = 1'b0;
      if (clear) begin
         state_d   = IDLE;
         cnt_d     = '0;
         blocked_d = 1'b1;
      end else if (blocked_q) begin
         state_d = IDLE;
         cnt_d   = '0;
         if (!pressed) blocked_d = 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (pressed) begin
                  step_req = 1'b1;
                  cnt_d    = '0;
                  state_d  = HOLD;
               end
            end
            HOLD: begin
               if (!pressed) begin
                  state_d = IDLE;
                  cnt_d   = '0;
               end else if (cnt_q == HOLD_LAST) begin
                  step_req = 1'b1;
                  cnt_d    = '0;
                  state_d  = REPEAT;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            REPEAT: begin
               if (!pressed) begin
                  state_d = IDLE;
                  cnt_d   = '0;
               end else if (cnt_q == REPEAT_LAST) begin
                  step_req = 1'b1;
                  cnt_d    = '0;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            default: begin
               state_d = IDLE;
               cnt_d   = '0;
            end
         endcase
      end
   end

endmodule

// File: rtl/setpoint_counter.sv
// Up/down setpoint register with BCD and binary views, driven by two buttons.
// Build option: define SETPOINT_WRAP_EN to wrap MAX<->MIN instead of saturating.
//   CLOCK_50   in  system clock
//   reset      in  asynchronous active-low reset
//   key_up_n   in  raw up button, active-low
//   key_dn_n   in  raw down button, active-low
//   load       in  single-cycle preset strobe
//   load_bcd   in  preset value, BCD, digit 0 in [3:0]
//   value_bcd  out current value, BCD
//   value_bin  out current value, binary
//   at_min     out value_bin == MIN_VAL
//   at_max     out value_bin == MAX_VAL
//   step       out one-cycle pulse on each key-caused change
module setpoint_counter
   import treadmill_pkg::*;
#(
   parameter int unsigned NUM_DIGITS    = 2,
   parameter int unsigned BIN_W         = 8,
   parameter int unsigned MIN_VAL       = 0,
   parameter int unsigned MAX_VAL       = 19,
   parameter int unsigned INIT_VAL      = 0,
   parameter int unsigned HOLD_CYCLES   = 25000000,
   parameter int unsigned REPEAT_CYCLES = 5000000
) (
   input  logic                    CLOCK_50,
   input  logic                    reset,
   input  logic                    key_up_n,
   input  logic                    key_dn_n,
   input  logic                    load,
   input  logic [4*NUM_DIGITS-1:0] load_bcd,
   output logic [4*NUM_DIGITS-1:0] value_bcd,
   output logic [BIN_W-1:0]        value_bin,
   output logic                    at_min,
   output logic                    at_max,
   output logic                    step
);

   localparam int unsigned BCD_W = 4 * NUM_DIGITS;

   localparam logic [BIN_W-1:0] MIN_BIN  = BIN_W'(MIN_VAL);
   localparam logic [BIN_W-1:0] MAX_BIN  = BIN_W'(MAX_VAL);
   localparam logic [BIN_W-1:0] INIT_BIN = BIN_W'(INIT_VAL);

   localparam logic [BCD_MAX_W-1:0] MIN_BCD_FULL  = bin_to_bcd(MIN_VAL);
   localparam logic [BCD_MAX_W-1:0] MAX_BCD_FULL  = bin_to_bcd(MAX_VAL);
   localparam logic [BCD_MAX_W-1:0] INIT_BCD_FULL = bin_to_bcd(INIT_VAL);
   localparam logic [BCD_W-1:0]     MIN_BCD       = BCD_W'(MIN_BCD_FULL);
   localparam logic [BCD_W-1:0]     MAX_BCD       = BCD_W'(MAX_BCD_FULL);
   localparam logic [BCD_W-1:0]     INIT_BCD      = BCD_W'(INIT_BCD_FULL);

   localparam logic [BCD_MAX_W-1:0] MIN_WIDE = BCD_MAX_W'(MIN_VAL);
   localparam logic [BCD_MAX_W-1:0] MAX_WIDE = BCD_MAX_W'(MAX_VAL);

   logic                 up_req, dn_req;
   logic                 up_pressed, dn_pressed;
   logic                 both_pressed_c;
   logic [BCD_MAX_W-1:0] load_wide, load_sum, cur_wide;
   logic                 load_ok;
   logic [BIN_W-1:0]     bin_d;
   logic [BCD_W-1:0]     bcd_d;
   logic                 step_d;

   // Both keys held cancels any step and forces a fresh press afterwards.
   assign both_pressed_c = up_pressed & dn_pressed;

   key_repeat #(
      .HOLD_CYCLES   (HOLD_CYCLES),
      .REPEAT_CYCLES (REPEAT_CYCLES)
   ) u_key_up (
      .CLOCK_50 (CLOCK_50),
      .reset    (reset),
      .key_n    (key_up_n),
      .clear    (both_pressed_c),
      .step_req (up_req),
      .pressed  (up_pressed)
   );

   key_repeat #(
      .HOLD_CYCLES   (HOLD_CYCLES),
      .REPEAT_CYCLES (REPEAT_CYCLES)
   ) u_key_dn (
      .CLOCK_50 (CLOCK_50),
      .reset    (reset),
      .key_n    (key_dn_n),
      .clear    (both_pressed_c),
      .step_req (dn_req),
      .pressed  (dn_pressed)
   );

   assign load_wide = BCD_MAX_W'(load_bcd);
   assign load_ok   = bcd_valid(load_wide, NUM_DIGITS);
   assign load_sum  = bcd_to_bin(load_wide, NUM_DIGITS);
   assign cur_wide  = BCD_MAX_W'(value_bcd);

   // Next value: a valid load wins over key steps; binary and BCD move together.
   always_comb begin
      bin_d  = value_bin;
      bcd_d  = value_bcd;
      step_d = 1'b0;
      if (load && load_ok) begin
         if (load_sum < MIN_WIDE) begin
            bin_d = MIN_BIN;
            bcd_d = MIN_BCD;
         end else if (load_sum > MAX_WIDE) begin
            bin_d = MAX_BIN;
            bcd_d = MAX_BCD;
         end else begin
            bin_d = BIN_W'(load_sum);
            bcd_d = load_bcd;
         end
      end else if (up_req) begin
         if (value_bin < MAX_BIN) begin
            bin_d  = value_bin + BIN_W'(1);
            bcd_d  = BCD_W'(bcd_inc(cur_wide, NUM_DIGITS));
            step_d = 1'b1;
         end
`ifdef SETPOINT_WRAP_EN
         else begin
            bin_d  = MIN_BIN;
            bcd_d  = MIN_BCD;
            step_d = 1'b1;
         end
`endif
      end else if (dn_req) begin
         if (value_bin > MIN_BIN) begin
            bin_d  = value_bin - BIN_W'(1);
            bcd_d  = BCD_W'(bcd_dec(cur_wide, NUM_DIGITS));
            step_d = 1'b1;
         end
`ifdef SETPOINT_WRAP_EN
         else begin
            bin_d  = MAX_BIN;
            bcd_d  = MAX_BCD;
            step_d = 1'b1;
         end
`endif
      end
   end

   // Value and step registers.
   always_ff @(posedge CLOCK_50 or negedge reset) begin
      if (!reset) begin
         value_bin <= INIT_BIN;
         value_bcd <= INIT_BCD;
         step      <= 1'b0;
      end else begin
         value_bin <= bin_d;
         value_bcd <= bcd_d;
         step      <= step_d;
      end
   end

   assign at_min = (value_bin == MIN_BIN);
   assign at_max = (value_bin == MAX_BIN);

endmodule

// File: doc/setpoint_counter.md
Name: setpoint_counter

Overview:
- Parametrised BCD/binary setpoint register driven by two active-low push-buttons (up/down).
- Next generation of the treadmill slope/speed adjust logic:
  - configurable digit count and range
  - synchronised, edge-detected keys
  - hold-to-auto-repeat
  - BCD preset load
  - range flags
- Sits between the DE-board KEY inputs and the 7-segment decoders and motor-control setpoint.

Parameters:
- NUM_DIGITS, 2, BCD digits on value_bcd (1..4).
- BIN_W, 8, width of value_bin; must hold MAX_VAL.
- MIN_VAL, 0, lower limit (binary).
- MAX_VAL, 19, upper limit (binary), MAX_VAL <= 10^NUM_DIGITS - 1.
- INIT_VAL, 0, value after reset, MIN_VAL <= INIT_VAL <= MAX_VAL.
- HOLD_CYCLES, 25000000, cycles a key must stay pressed before auto-repeat starts (0.5 s at 50 MHz).
- REPEAT_CYCLES, 5000000, cycles between auto-repeat steps (0.1 s).

Ports:
- CLOCK_50  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- key_up_n  in  1  raw up button, active-low, asynchronous to clock.
- key_dn_n  in  1  raw down button, active-low, asynchronous to clock.
- load  in  1  single-cycle preset strobe.
- load_bcd  in  4*NUM_DIGITS  preset value, BCD, digit 0 in [3:0].
- value_bcd  out  4*NUM_DIGITS  current value, BCD.
- value_bin  out  BIN_W  current value, binary.
- at_min  out  1  value_bin == MIN_VAL.
- at_max  out  1  value_bin == MAX_VAL.
- step  out  1  one-cycle pulse on every key-caused value change.

Behaviour:
- Clock and reset: one clock, CLOCK_50. Reset is asynchronous and active-low, on port reset.
- Reset values:
  - value_bin = INIT_VAL; value_bcd = BCD(INIT_VAL).
  - at_min/at_max reflect INIT_VAL; step = 0.
  - sync flops = 1 (released); both key FSMs in IDLE; hold/repeat counters = 0.
- Synchronisation:
  - Each key passes through a 2-flop synchroniser.
  - A key sampled low at edge N is seen by the FSM at edge N+2; value and step update at that edge (2-cycle latency, registered outputs).
- Per-key FSM states: IDLE, HOLD, REPEAT.
  - IDLE: on synced low, request one step, counter = 0, go to HOLD.
  - HOLD: counter increments each cycle. On synced high, go to IDLE. When counter == HOLD_CYCLES-1, request a step, counter = 0, go to REPEAT.
  - REPEAT: counter increments. When counter == REPEAT_CYCLES-1, request a step, counter = 0. On synced high, go to IDLE.
- Both keys synced low in the same cycle:
  - No step.
  - Both FSMs forced to IDLE and held there until the respective key releases.
  - A fresh press is then required.
- Up step:
  - If value_bin < MAX_VAL: value_bin + 1; BCD incremented with per-digit carry (9 -> 0, carry to next digit). step = 1.
  - Else saturate: no change, step = 0.
- Down step:
  - If value_bin > MIN_VAL: value_bin - 1; BCD decremented with per-digit borrow (0 -> 9). step = 1.
  - Else saturate: no change, step = 0.
- No division in the update path; binary and BCD are updated in lockstep.
- Load:
  - Converts load_bcd to binary (weighted sum), clamps to [MIN_VAL, MAX_VAL], and writes both representations next edge.
  - Load has priority over a same-cycle key step; step = 0 that cycle; key FSM states are unaffected.
  - If any digit > 9, the load is ignored entirely.
- at_min and at_max are combinational compares of registered value_bin.
- Reset mid-hold or mid-repeat: immediate return to reset values; a key still held after reset release counts as a fresh press (sync flops come out of reset at 1).

Optional Feature:
- Macro: SETPOINT_WRAP_EN.
- Defined:
  - An up step at MAX_VAL goes to MIN_VAL, and a down step at MIN_VAL goes to MAX_VAL.
  - BCD is reloaded from constants; step = 1 on wrap.
- Undefined: saturating behaviour as above.
- Load clamping applies in both builds.

Decomposition:
- Package treadmill_pkg:
  - bcd_digit_t (4-bit) type and DIGIT_MAX = 9.
  - key_state_t enum {IDLE, HOLD, REPEAT}.
  - bcd_inc/bcd_dec/bcd_to_bin functions.
- Sub-module key_repeat:
  - Contains synchroniser, per-key FSM and counter.
  - Inputs: clock, reset, key_n, clear. Outputs: step_req, pressed (synced).
  - Instantiated twice.
- The top block handles arbitration, the both-pressed clear, load, arithmetic and flags.

Test Plan:
- All tests use HOLD_CYCLES = 8 and REPEAT_CYCLES = 4.
- Reset: assert reset low mid-run -> value_bin = 0, value_bcd = 8'h00, at_min = 1, step = 0 asynchronously.
- Single tap: key_up_n low for 3 cycles from value 9 -> value_bcd = 8'h10, value_bin = 10, one step pulse exactly 2 edges after the key is sampled.
- Auto-repeat: hold key_up_n for 30 cycles from 0 -> steps at press+2, +10, +14, +18, +22, +26, +30 (edge count); value 7; then release -> no further steps.
- Saturation: from 19, tap up -> value stays 19, at_max = 1, step = 0; tap down from 0 -> stays 0. With SETPOINT_WRAP_EN: 19 -> 0 and 0 -> 19, step = 1.
- Both keys: press up, then press down while up is held -> no steps while both are low. Release down only -> no step. Release and re-press up -> one step.
- Load:
  - load_bcd = 8'h25 -> value 19 (clamped).
  - load_bcd = 8'h0A -> ignored.
  - load_bcd = 8'h07 with a same-cycle up step -> 7, step = 0.
